clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Run-time controller for the programmable clock divider path. Accepts divide-ratio requests over a req/ack handshake and runs a terminal-count divider. Produces a one-cycle `tick` enable and a near-50% `sq_out` square wave. Ratio changes take effect only at a period boundary, so no output period is ever truncated. Sits between the board-level control logic and the divided-clock consumers, and replaces the fixed-ratio dividers for any ratio chosen at run time.

## Interface
Parameters:
- `CNT_W`, default 8: width of the divide ratio and the period counter. Maximum ratio is 2^CNT_W−1.

Ports:
- `clk`, input, 1: single system clock; all logic on posedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `div_req`, input, 1: ratio request. The requester holds it, with `div_val` stable, until it sees `div_ack`.
- `div_val`, input, CNT_W: requested ratio N. N=0 means stop.
- `div_ack`, output, 1: one-cycle acceptance pulse.
- `busy`, output, 1: high when state ≠ IDLE.
- `cur_div`, output, CNT_W: ratio currently in effect; 0 when idle.
- `tick`, output, 1: one-cycle pulse on the last cycle of each period.
- `sq_out`, output, 1: square wave; high for ceil(N/2) cycles, then low for floor(N/2) cycles.

## Operation
- State machine:
  - IDLE: divider stopped.
  - RUN: counting with `cur_div`.
  - PEND: counting with `cur_div`; a new ratio is held in `pend_div`.
- Period counter `cnt` counts 0..N−1 and wraps to 0. `tick` = RUN|PEND and `cnt`==N−1.
- `sq_out` = RUN|PEND and `cnt` < ceil(N/2). Both outputs decode registered state only; there is no combinational path from any input.
- Acceptance:
  - `div_req` is sampled at posedge when state is IDLE or RUN and `div_ack` is low.
  - `div_ack` pulses for the following cycle.
  - `div_req` is ignored while `div_ack` is high and while in PEND. Back-pressure in PEND is expressed only by withholding `div_ack`.
- Transitions:
  - IDLE + accept N>0: enter RUN, `cur_div`=N, `cnt`=0.
  - IDLE + accept N=0: stay in IDLE; `div_ack` still pulses.
  - RUN + accept, where the sampling edge is not a terminal edge: store `pend_div`, enter PEND.
  - RUN + accept on the terminal edge (`tick` high in that cycle): apply the new ratio immediately, `cnt`=0, stay in RUN (or go to IDLE if N=0).
  - PEND + terminal edge, `pend_div`>0: `cur_div`=`pend_div`, `cnt`=0, enter RUN.
  - PEND + terminal edge, `pend_div`=0: enter IDLE, `cur_div`=0.
  - Stop always completes the current period; the final `tick` is issued.
- N=1: `tick` high every cycle, `sq_out` constantly high.
- Reset values (async assert): state IDLE, `cnt`=0, `cur_div`=0, `pend_div`=0, `div_ack`=0, `busy`=0, `tick`=0, `sq_out`=0.
  - Reset mid-operation discards any pending request.
  - Release is synchronous to `clk` at the next posedge.

## Timing
- IDLE accept at edge k (`div_req` sampled high): `div_ack` high in cycle k+1, `cnt`=0 in k+1, first `tick` in cycle k+N.
- Steady state: `tick` period is exactly N cycles; `sq_out` rises in the cycle after `tick`.
- PEND switch: new period starts the cycle after the old ratio's `tick`. The old period is never shortened.
- Handshake latency: 1 cycle from IDLE/RUN. In PEND, up to N_old cycles plus 1.

## Configuration
- `CLK_DIV_CTRL_STATS_EN` defined:
  - Adds output `tick_cnt` [15:0], counting `tick` pulses and wrapping from 0xFFFF to 0.
  - `tick_cnt` clears to 0 on reset and on every ratio change (including start from IDLE).
  - Adds input `stats_clr`, a synchronous clear that takes priority over increment in the same cycle.
- Undefined: neither port exists, and no counter logic is generated.

## Structure
- Package `clk_div_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`, `ST_PEND`);
  - the default `CNT_W`;
  - the stats width constant (16).
- Sub-module `clk_div_core` contains `cnt`, the wrap logic and `tick`/`sq_out` decode. It has inputs `run`, `ratio` and `restart`. `clk_div_ctrl` keeps the state machine, handshake and pending register.

## Test plan
- Reset, then request N=4: `div_ack` pulse 1 cycle after the sample, `tick` every 4 cycles, `sq_out` high 2 / low 2, `cur_div`=4.
- N=5 then N=1: `sq_out` high 3 / low 2; after switching, `tick` and `sq_out` are high every cycle.
- RUN with N=6, request N=3 at `cnt`=1: PEND holds `div_ack` low, the 6-cycle period completes, the first 3-cycle period follows, and `div_ack` pulses.
- Request N=0 while running N=8 at `cnt`=2: the final `tick` occurs at `cnt`=7, then IDLE, `busy`=0, `sq_out`=0.
- Request landing exactly on the terminal edge with N=2→N=7: no PEND state; the 7-cycle period begins next cycle.
- Assert `rst_n` low mid-PEND: all outputs go to 0 immediately. After release, with `CLK_DIV_CTRL_STATS_EN`, `tick_cnt`=0 and the count wraps 0xFFFF→0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } div_state_e;

    localparam int DEF_CNT_W = 8;
    localparam int STATS_W   = 16;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio request handshake and divider outputs between requester and clk_div_ctrl.
interface clk_div_ctrl_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             busy;
    logic [CNT_W-1:0] cur_div;
    logic             tick;
    logic             sq_out;

    modport master (
        output div_req,
        output div_val,
        input  div_ack,
        input  busy,
        input  cur_div,
        input  tick,
        input  sq_out
    );

    modport slave (
        input  div_req,
        input  div_val,
        output div_ack,
        output busy,
        output cur_div,
        output tick,
        output sq_out
    );
endinterface

// File: rtl/clk_div_core.sv
// Period counter for the divider: counts 0..ratio-1 and decodes tick / sq_out
// from registered state only.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] ratio,
    input  logic             restart,
    output logic             tick,
    output logic             sq_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;
    logic [CNT_W:0]   half_up;

    assign last    = ratio - {{(CNT_W-1){1'b0}}, 1'b1};
    // ceil(ratio/2) needs one extra bit so the maximum ratio does not overflow
    assign half_up = ({1'b0, ratio} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !run) begin
            cnt_d = '0;
        end else if (cnt_q == last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick   = run && (cnt_q == last);
    assign sq_out = run && ({1'b0, cnt_q} < half_up);

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time divider controller: req/ack ratio handshake, boundary-aligned ratio switching.
// Optional tick statistics counter enabled with CLK_DIV_CTRL_STATS_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | divider stopped, cur_div = 0
// RUN     | counting with cur_div, requests accepted
// PEND    | counting with cur_div, next ratio waiting in pend_div
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef CLK_DIV_CTRL_STATS_EN
    input  logic               stats_clr,
    output logic [STATS_W-1:0] tick_cnt,
`endif
    clk_div_ctrl_if.slave      bus
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             ack_q, ack_d;
    logic             accept;
    logic             load;
    logic             run_w;
    logic             tick_w;
    logic             sq_w;

    assign run_w  = (state_q != ST_IDLE);
    // No sampling while ack is out or while a ratio is already pending
    assign accept = bus.div_req && !ack_q &&
                    ((state_q == ST_IDLE) || (state_q == ST_RUN));

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        ack_d      = 1'b0;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ack_d = 1'b1;
                    if (bus.div_val != '0) begin
                        state_d   = ST_RUN;
                        cur_div_d = bus.div_val;
                        load      = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    ack_d = 1'b1;
                    if (tick_w) begin
                        if (bus.div_val == '0) begin
                            state_d   = ST_IDLE;
                            cur_div_d = '0;
                        end else begin
                            cur_div_d = bus.div_val;
                            load      = 1'b1;
                        end
                    end else begin
                        pend_div_d = bus.div_val;
                        state_d    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (tick_w) begin
                    pend_div_d = '0;
                    if (pend_div_q == '0) begin
                        state_d   = ST_IDLE;
                        cur_div_d = '0;
                    end else begin
                        state_d   = ST_RUN;
                        cur_div_d = pend_div_q;
                        load      = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_div_q  <= '0;
            pend_div_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            ack_q      <= ack_d;
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run_w),
        .ratio   (cur_div_q),
        .restart (load),
        .tick    (tick_w),
        .sq_out  (sq_w)
    );

    assign bus.div_ack = ack_q;
    assign bus.busy    = run_w;
    assign bus.cur_div = cur_div_q;
    assign bus.tick    = tick_w;
    assign bus.sq_out  = sq_w;

`ifdef CLK_DIV_CTRL_STATS_EN
    logic [STATS_W-1:0] tick_cnt_q;
    logic               ratio_chg;

    // A stop (cur_div -> 0) also counts as a ratio change
    assign ratio_chg = load || (cur_div_d != cur_div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (stats_clr || ratio_chg) begin
            tick_cnt_q <= '0;
        end else if (tick_w) begin
            tick_cnt_q <= tick_cnt_q + {{(STATS_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a per-cycle vector table plus hand-written corner sequences.
module tb_clk_div_ctrl;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_div_ctrl_if #(.CNT_W(W)) bif ();

`ifdef CLK_DIV_CTRL_STATS_EN
    logic        stats_clr;
    logic [15:0] tick_cnt;
`endif

    clk_div_ctrl #(
        .CNT_W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CLK_DIV_CTRL_STATS_EN
        .stats_clr (stats_clr),
        .tick_cnt  (tick_cnt),
`endif
        .bus       (bif.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic         req;
        logic [W-1:0] val;
        logic         ack;
        logic         busy;
        logic [W-1:0] cur;
        logic         tick;
        logic         sq;
    } vec_t;

    vec_t tbl[33];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return {20'd0, bif.div_ack, bif.busy, bif.cur_div, bif.tick, bif.sq_out};
    endfunction

    // Check this cycle's outputs, then drive the inputs sampled at its closing edge.
    task automatic cyc(input logic req, input logic [W-1:0] val,
                       input logic e_ack, input logic e_busy, input logic [W-1:0] e_cur,
                       input logic e_tick, input logic e_sq, input string nm);
        @(negedge clk);
        cmp(nm, outs(), {20'd0, e_ack, e_busy, e_cur, e_tick, e_sq});
        bif.div_req = req;
        bif.div_val = val;
    endtask

    // Steady running cycles with ratio n for counter values c0..c1.
    task automatic run_seg(input int n, input int c0, input int c1, input string nm);
        for (int c = c0; c <= c1; c++)
            cyc(1'b0, '0, 1'b0, 1'b1, W'(n), (c == n - 1), (c < (n + 1) / 2), nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bif.div_req = 1'b0;
        bif.div_val = '0;
`ifdef CLK_DIV_CTRL_STATS_EN
        stats_clr = 1'b0;
`endif
        //              req  val  ack busy cur tick sq
        tbl[0]  = '{1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'd4, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 8'd1, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1};
        tbl[22] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
        tbl[25] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
        tbl[26] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
        tbl[27] = '{1'b1, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1};
        tbl[28] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[29] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[30] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[31] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[32] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        cmp("reset_outputs", outs(), 32'd0);
`ifdef CLK_DIV_CTRL_STATS_EN
        cmp("reset_tick_cnt", {16'd0, tick_cnt}, 32'd0);
`endif
        rst_n = 1'b1;

        // N=4, terminal-edge switch to 5, PEND switch to 1, stop on terminal, idle N=0
        for (int i = 0; i < 33; i++)
            cyc(tbl[i].req, tbl[i].val, tbl[i].ack, tbl[i].busy, tbl[i].cur,
                tbl[i].tick, tbl[i].sq, $sformatf("tbl[%0d]", i));

        // N=6, request 3 at cnt=1; a second request held during PEND waits for RUN
        cyc(1'b1, 8'd6, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "pend_start");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b1, "pend_run_ack");
        cyc(1'b1, 8'd3, 1'b0, 1'b1, 8'd6, 1'b0, 1'b1, "pend_req");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b1, "pend_ack");
        cyc(1'b1, 8'd2, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, "pend_hold_c3");
        cyc(1'b1, 8'd2, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, "pend_hold_c4");
        cyc(1'b1, 8'd2, 1'b0, 1'b1, 8'd6, 1'b1, 1'b0, "pend_last6");
        cyc(1'b1, 8'd2, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, "pend_first3");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, "pend_late_ack");
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, "pend_last3");
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, "n2_c0");

        // Request landing on the terminal edge: 2 -> 7 without PEND
        cyc(1'b1, 8'd7, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, "term_req");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b1, "term_ack");
        run_seg(7, 1, 6, "n7_a");
        cyc(1'b1, 8'd8, 1'b0, 1'b1, 8'd7, 1'b0, 1'b1, "n7_req8");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b1, "n7_ack8");
        run_seg(7, 2, 6, "n7_b");

        // Stop requested at cnt=2 of N=8: period completes with final tick
        run_seg(8, 0, 1, "n8_head");
        cyc(1'b1, 8'd0, 1'b0, 1'b1, 8'd8, 1'b0, 1'b1, "stop_req");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd8, 1'b0, 1'b1, "stop_ack");
        run_seg(8, 4, 7, "n8_tail");
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "stop_idle0");
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "stop_idle1");

        // Async reset while PEND holds ratio 9
        cyc(1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "rp_start");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b1, "rp_ack");
        cyc(1'b1, 8'd9, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, "rp_req");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, "rp_pend");
        #2 rst_n = 1'b0;
        #1 cmp("rst_async_outputs", outs(), 32'd0);
`ifdef CLK_DIV_CTRL_STATS_EN
        cmp("rst_async_tick_cnt", {16'd0, tick_cnt}, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "post_rst_idle");
        cyc(1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "n3_start");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, "n3_ack");
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, "n3_c1");
        cyc(1'b1, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, "n3_stop");
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "n3_stop_ack");
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "n3_idle");

`ifdef CLK_DIV_CTRL_STATS_EN
        // Tick counting, clear priority, and 16-bit wrap with N=1
        cyc(1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "st_start");
        cyc(1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b1, "st_ack");
        cmp("st_cnt_start", {16'd0, tick_cnt}, 32'd0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1, "st_run1");
        cmp("st_cnt_1", {16'd0, tick_cnt}, 32'd1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1, "st_run2");
        cmp("st_cnt_2", {16'd0, tick_cnt}, 32'd2);
        stats_clr = 1'b1;
        @(negedge clk);
        cmp("st_clr_over_tick", {16'd0, tick_cnt}, 32'd0);
        stats_clr = 1'b0;
        repeat (65535) @(negedge clk);
        cmp("st_cnt_max", {16'd0, tick_cnt}, 32'h0000_FFFF);
        @(negedge clk);
        cmp("st_cnt_wrap", {16'd0, tick_cnt}, 32'd0);
        @(negedge clk);
        cmp("st_cnt_after_wrap", {16'd0, tick_cnt}, 32'd1);
        #2 rst_n = 1'b0;
        #1 cmp("st_rst_tick_cnt", {16'd0, tick_cnt}, 32'd0);
        cmp("st_rst_outputs", outs(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
